// File: rtl/serial_parity_pkg.sv
// -----------------------------------------------------------------------------
// serial_parity_pkg
// Shared constants for the serial parity receiver: receiver state encodings,
// default frame geometry and helpers that size the bit counter from the
// data width of a given instance.
// -----------------------------------------------------------------------------
package serial_parity_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int FRAME_BITS     = DEFAULT_DATA_W + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    // Data bits plus the trailing parity bit.
    function automatic int frame_bits(input int data_w);
        return data_w + 1;
    endfunction

    // Bit counter must reach DATA_W, the index of the parity bit.
    function automatic int cnt_width(input int data_w);
        return $clog2(frame_bits(data_w));
    endfunction

endpackage

// File: rtl/serial_parity_rx_parity_reduce.sv
// -----------------------------------------------------------------------------
// parity_reduce
// Combinational XOR reduction of a W-bit vector.
//   vec : input vector
//   par : 1 when vec holds an odd number of ones
// -----------------------------------------------------------------------------
module parity_reduce #(
    parameter int W = 9
) (
    input  logic [W-1:0] vec,
    output logic         par
);

    assign par = ^vec;

endmodule

// File: rtl/serial_parity_rx.sv
// -----------------------------------------------------------------------------
// serial_parity_rx
// Shifts in a serial frame of DATA_W data bits (LSB first) followed by one
// parity bit, checks parity over the whole frame and presents the data with
// an error flag through a one-entry valid/ready output register.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bit_valid    qualifies bit_in / frame_start
//   bit_in       serial data or parity bit
//   frame_start  with bit_valid: bit_in is data bit 0 of a new frame
//   out_valid    out_data / out_perr hold a received frame
//   out_ready    consumer accepts on out_valid && out_ready
//   out_data     received data, bit 0 = first bit on the line
//   out_perr     parity check failed for this frame
//   err_count    saturating count of frames with a parity error
//   overrun      sticky: a completed frame was dropped (output full)
//   clr_err      clears err_count and overrun
//
// State | Meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a frame_start bit
// RECV  | collecting data bits at index cnt; cnt == DATA_W is parity
// -----------------------------------------------------------------------------
module serial_parity_rx
    import serial_parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 frame_start,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_perr,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 overrun,
    input  logic                 clr_err
);

    localparam int                   CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(DATA_W);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    logic [0:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;

    logic frame_done;
    logic frame_par;
    logic perr;
    logic buf_open;
    logic drop;

    // A frame_start bit always wins over the parity slot, so a restart in the
    // last position never completes the old frame.
    assign frame_done = bit_valid && !frame_start && (state == RECV) && (cnt == LAST_IDX);

    // Parity is checked over the stored data and the parity bit on the line.
    parity_reduce #(
        .W (DATA_W + 1)
    ) u_parity_reduce (
        .vec ({bit_in, shreg}),
        .par (frame_par)
    );

    assign perr     = frame_par ^ (PARITY_ODD != 0);
    assign buf_open = !out_valid || out_ready;
    assign drop     = frame_done && !buf_open;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else if (bit_valid) begin
            if (frame_start) begin
                state <= RECV;
                cnt   <= CNT_W'(1);
                shreg <= DATA_W'(bit_in);
            end else if (state == RECV) begin
                if (cnt == LAST_IDX) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    // Upper bits were cleared at frame start, so OR-in is enough.
                    shreg <= shreg | (DATA_W'(bit_in) << cnt);
                    cnt   <= cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_perr  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // Loading in the handshake cycle overrides the clear above.
            if (frame_done && buf_open) begin
                out_valid <= 1'b1;
                out_data  <= shreg;
                out_perr  <= perr;
            end
        end
    end

    // Dropped frames still count; a clear never swallows a same-cycle event.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
            overrun   <= 1'b0;
        end else begin
            if (clr_err) begin
                err_count <= (frame_done && perr) ? ERR_CNT_W'(1) : '0;
            end else if (frame_done && perr && (err_count != ERR_MAX)) begin
                err_count <= err_count + 1'b1;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
